// File: rtl/led_brt_seq_pkg.sv
// Shared constants and types for the AFE4403 LED brightness sequencer.
// Register addresses, frame state encoding and CONTROL0 bit helpers.
package led_brt_seq_pkg;

  localparam logic [7:0] AFE_CONTROL0 = 8'h00;
  localparam logic [7:0] AFE_LEDCNTRL = 8'h22;
  localparam int         SPI_READ     = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL_W,
    ST_GAP,
    ST_LED_W,
    ST_CTRL_R
  } frm_st_t;

  function automatic logic [7:0] ctrl_word(
    input logic rd
  );
    logic [7:0] w;
    w = 8'h00;
    if (rd)
      w = 8'(1 << SPI_READ);
    return w;
  endfunction

endpackage

// File: rtl/led_brt_seq_if.sv
// Byte-engine handshake between the sequencer and the shared SPI shifter.
// The sequencer owns data/valid/frame; the engine answers with done.
interface led_brt_seq_if;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_frame;
  logic       spi_done;

  modport master (
    output tx_valid,
    output tx_data,
    output tx_frame,
    input  spi_done
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  tx_frame,
    output spi_done
  );

endinterface

// File: rtl/led_code_step.sv
// One-channel brightness step: saturating or modulo-256 +/- STEP.
// Conflicting inc and dec leave the code untouched.
module led_code_step #(
  parameter int STEP = 1,
  parameter int WRAP = 0
) (
  input  logic [7:0] cur,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] nxt
);

  localparam logic [8:0] S   = 9'(STEP);
  localparam logic       SAT = (WRAP == 0);

  logic [8:0] up;
  logic [8:0] dn;

  always_comb begin
    up  = {1'b0, cur} + S;
    dn  = {1'b0, cur} - S;
    nxt = cur;
    unique case (1'b1)
      inc & ~dec:
        nxt = (up[8] & SAT) ? 8'hFF : up[7:0];
      dec & ~inc:
        nxt = (dn[8] & SAT) ? 8'h00 : dn[7:0];
      default:
        nxt = cur;
    endcase
  end

endmodule

// File: rtl/led_brt_seq.sv
// AFE4403 LED current sequencer: rate-limited code adjust plus
// CONTROL0/LEDCNTRL/CONTROL0 write sequence over the SPI byte engine.
module led_brt_seq
  import led_brt_seq_pkg::*;
#(
  parameter int         NUM_CH     = 2,
  parameter int         VAL_W      = 8,
  parameter logic [7:0] INIT_VAL   = 8'h14,
  parameter int         STEP       = 1,
  parameter int         ADJ_PERIOD = 40000,
  parameter int         WRAP       = 0,
  parameter int         GAP_CYC    = 2,
  parameter logic [7:0] CTRL_ADDR  = AFE_CONTROL0,
  parameter logic [7:0] LED_ADDR   = AFE_LEDCNTRL
) (
  input  logic                  div_clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     inc,
  input  logic [NUM_CH-1:0]     dec,
  input  logic                  load,
  input  logic [NUM_CH*8-1:0]   load_val,
  input  logic [1:0]            led_range,
  led_brt_seq_if.master         bus,
  output logic [NUM_CH*8-1:0]   led_val,
  output logic                  busy,
  output logic                  adj_tick
);

  localparam int CW = (ADJ_PERIOD > 1) ? $clog2(ADJ_PERIOD) : 1;
  localparam int GW = $clog2(GAP_CYC + 1);

  logic [CW-1:0]    cnt;
  logic [VAL_W-1:0] code     [NUM_CH];
  logic [VAL_W-1:0] step_nxt [NUM_CH];
  logic [NUM_CH-1:0] diff;
  logic             change;

  frm_st_t          state;
  frm_st_t          nxt_st;
  logic [1:0]       idx;
  logic [GW-1:0]    gcnt;
  logic             pending;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_frame;
  logic [1:0]       sh_rng;
  logic [7:0]       sh0;
  logic [7:0]       sh1;

  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_data;
  assign bus.tx_frame = tx_frame;

  assign adj_tick = (cnt == '0);

  always_ff @(posedge div_clk) begin
    if (rst || cnt == CW'(ADJ_PERIOD - 1))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_code_step #(
      .STEP (STEP),
      .WRAP (WRAP)
    ) u_step (
      .cur (code[g]),
      .inc (inc[g]),
      .dec (dec[g]),
      .nxt (step_nxt[g])
    );
    assign diff[g] = (step_nxt[g] != code[g]);
    assign led_val[g*8 +: 8] = code[g];
  end

  assign change = load | (adj_tick & (|diff));

  always_ff @(posedge div_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst)
        code[i] <= INIT_VAL;
      else if (load)
        code[i] <= load_val[i*8 +: 8];
      else if (adj_tick)
        code[i] <= step_nxt[i];
    end
  end

  function automatic logic [7:0] frame_byte(
    input frm_st_t    st,
    input logic [1:0] i
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (1'b1)
      st == ST_CTRL_W:
        b = (i == 2'd0) ? CTRL_ADDR : 8'h00;
      st == ST_LED_W: begin
        case (i)
          2'd0:    b = LED_ADDR;
          2'd1:    b = {6'b0, sh_rng};
          2'd2:    b = sh0;
          default: b = sh1;
        endcase
      end
      st == ST_CTRL_R: begin
        if (i == 2'd0)
          b = CTRL_ADDR;
        else if (i == 2'd3)
          b = ctrl_word(1'b1);
      end
      default:
        b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge div_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      nxt_st   <= ST_IDLE;
      idx      <= '0;
      gcnt     <= '0;
      pending  <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_frame <= 1'b0;
      busy     <= 1'b0;
      sh_rng   <= 2'b00;
      sh0      <= 8'h00;
      sh1      <= 8'h00;
    end else begin
      pending <= pending | change;
      unique case (state)
        ST_IDLE: begin
          if (pending) begin
            state    <= ST_CTRL_W;
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_frame <= 1'b1;
            tx_data  <= CTRL_ADDR;
            busy     <= 1'b1;
            pending  <= change;
          end
        end
        ST_CTRL_W, ST_LED_W, ST_CTRL_R: begin
          if (bus.spi_done) begin
            if (idx == 2'd3) begin
              state    <= ST_GAP;
              gcnt     <= '0;
              tx_valid <= 1'b0;
              tx_frame <= 1'b0;
              tx_data  <= 8'h00;
              unique case (state)
                ST_CTRL_W: nxt_st <= ST_LED_W;
                ST_LED_W:  nxt_st <= ST_CTRL_R;
                default:   nxt_st <= ST_IDLE;
              endcase
            end else begin
              idx     <= idx + 2'd1;
              tx_data <= frame_byte(state, idx + 2'd1);
            end
          end
        end
        ST_GAP: begin
          if (gcnt != GW'(GAP_CYC - 1)) begin
            gcnt <= gcnt + 1'b1;
          end else begin
            idx <= '0;
            unique case (nxt_st)
              ST_LED_W: begin
                // snapshot codes; later changes ride the next sequence
                state    <= ST_LED_W;
                sh_rng   <= led_range;
                sh0      <= code[0];
                sh1      <= (NUM_CH > 1) ? code[NUM_CH-1] : 8'h00;
                tx_valid <= 1'b1;
                tx_frame <= 1'b1;
                tx_data  <= LED_ADDR;
              end
              ST_CTRL_R: begin
                state    <= ST_CTRL_R;
                tx_valid <= 1'b1;
                tx_frame <= 1'b1;
                tx_data  <= CTRL_ADDR;
              end
              default: begin
                if (pending) begin
                  state    <= ST_CTRL_W;
                  tx_valid <= 1'b1;
                  tx_frame <= 1'b1;
                  tx_data  <= CTRL_ADDR;
                  pending  <= change;
                end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end
              end
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_brt_seq.sv
// Directed + randomized bench for led_brt_seq with a byte-level model.
// Three instances cover saturate/step-1, saturate/step-4 and wrap/step-4.
module tb_led_brt_seq;

  localparam int GAP = 2;
  localparam int ADJ = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  inc_a;
  logic [1:0]  dec_a;
  logic [1:0]  inc_bc;
  logic        load;
  logic [15:0] load_val;
  logic [1:0]  rng;
  logic [15:0] lv_a, lv_b, lv_c;
  logic        busy_a, busy_b, busy_c;
  logic        tick_a, tick_b, tick_c;

  always #5 clk = ~clk;

  led_brt_seq_if bus_a ();
  led_brt_seq_if bus_b ();
  led_brt_seq_if bus_c ();

  assign bus_b.spi_done = bus_b.tx_valid;
  assign bus_c.spi_done = bus_c.tx_valid;

  led_brt_seq #(
    .NUM_CH(2), .VAL_W(8), .INIT_VAL(8'h14), .STEP(1),
    .ADJ_PERIOD(ADJ), .WRAP(0), .GAP_CYC(GAP),
    .CTRL_ADDR(8'h00), .LED_ADDR(8'h22)
  ) u_a (
    .div_clk(clk), .rst(rst), .inc(inc_a), .dec(dec_a),
    .load(load), .load_val(load_val), .led_range(rng),
    .bus(bus_a), .led_val(lv_a), .busy(busy_a), .adj_tick(tick_a)
  );

  led_brt_seq #(
    .NUM_CH(2), .VAL_W(8), .INIT_VAL(8'h14), .STEP(4),
    .ADJ_PERIOD(ADJ), .WRAP(0), .GAP_CYC(GAP),
    .CTRL_ADDR(8'h00), .LED_ADDR(8'h22)
  ) u_b (
    .div_clk(clk), .rst(rst), .inc(inc_bc), .dec(2'b00),
    .load(load), .load_val(load_val), .led_range(rng),
    .bus(bus_b), .led_val(lv_b), .busy(busy_b), .adj_tick(tick_b)
  );

  led_brt_seq #(
    .NUM_CH(2), .VAL_W(8), .INIT_VAL(8'h14), .STEP(4),
    .ADJ_PERIOD(ADJ), .WRAP(1), .GAP_CYC(GAP),
    .CTRL_ADDR(8'h00), .LED_ADDR(8'h22)
  ) u_c (
    .div_clk(clk), .rst(rst), .inc(inc_bc), .dec(2'b00),
    .load(load), .load_val(load_val), .led_range(rng),
    .bus(bus_c), .led_val(lv_c), .busy(busy_c), .adj_tick(tick_c)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  int         rsp_dly = 0;
  logic [7:0] cap [$];
  logic [7:0] expq [$];
  logic [1:0] tr [$];
  bit         tr_en = 0;
  bit         seen_b = 0;
  int         mc [2];
  bit         mchg;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI byte engine for u_a: waits rsp_dly cycles per byte, logs bytes
  initial begin
    int         cnt;
    logic [7:0] held;
    cnt  = 0;
    held = 8'h00;
    bus_a.spi_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_a.spi_done) begin
        bus_a.spi_done = 1'b0;
        cnt = 0;
      end else if (bus_a.tx_valid) begin
        if (cnt == 0) held = bus_a.tx_data;
        chk("frame_hi", bus_a.tx_frame, 1);
        if (cnt >= rsp_dly) begin
          if (rsp_dly > 0) chk("data_stable", bus_a.tx_data, held);
          cap.push_back(bus_a.tx_data);
          bus_a.spi_done = 1'b1;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tr_en) tr.push_back({busy_a, bus_a.tx_frame});
      if (busy_b) seen_b = 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic void model_apply(input logic [1:0] ia,
      input logic [1:0] da, input logic ld, input logic [15:0] lv);
    mchg = 0;
    if (ld) begin
      mc[0] = int'(lv[7:0]);
      mc[1] = int'(lv[15:8]);
      mchg  = 1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (ia[c] != da[c]) begin
          int r;
          r = ia[c] ? mc[c] + 1 : mc[c] - 1;
          if (r > 255) r = 255;
          if (r < 0) r = 0;
          if (r != mc[c]) mchg = 1;
          mc[c] = r;
        end
      end
    end
  endfunction

  function automatic logic [15:0] model_led();
    return {8'(mc[1]), 8'(mc[0])};
  endfunction

  function automatic void push_seq(input int c0, input int c1,
                                   input logic [1:0] r);
    expq.push_back(8'h00); expq.push_back(8'h00);
    expq.push_back(8'h00); expq.push_back(8'h00);
    expq.push_back(8'h22); expq.push_back({6'b0, r});
    expq.push_back(8'(c0)); expq.push_back(8'(c1));
    expq.push_back(8'h00); expq.push_back(8'h00);
    expq.push_back(8'h00); expq.push_back(8'h01);
  endfunction

  task automatic do_tick(input logic [1:0] ia, input logic [1:0] da,
      input logic [1:0] ibc, input logic ld, input logic [15:0] lv);
    int i;
    i = 0;
    while (!tick_a && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("tick_wait", tick_a, 1);
    inc_a = ia; dec_a = da; inc_bc = ibc;
    load = ld; load_val = lv;
    model_apply(ia, da, ld, lv);
    @(negedge clk);
    inc_a = 0; dec_a = 0; inc_bc = 0; load = 0;
  endtask

  task automatic settle(input string tag);
    int i;
    i = 0;
    repeat (3) @(negedge clk);
    while ((busy_a | busy_b | busy_c) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_idle"}, busy_a | busy_b | busy_c, 0);
  endtask

  task automatic cmp_cap(input string tag);
    chk({tag, "_nbytes"}, cap.size(), expq.size());
    for (int k = 0; k < expq.size() && k < cap.size(); k++)
      chk($sformatf("%s_byte%0d", tag, k), cap[k], expq[k]);
  endtask

  task automatic chk_gaps(input string tag, input int nseq);
    bit   seen, pf, pb;
    int   run, ng, bad, brise;
    seen = 0; pf = 0; pb = 0;
    run = 0; ng = 0; bad = 0; brise = 0;
    foreach (tr[k]) begin
      if (tr[k][1] && !pb) brise++;
      if (tr[k][0] && !pf && seen) begin
        ng++;
        if (run != GAP) bad++;
      end
      if (tr[k][0]) begin
        seen = 1;
        run  = 0;
      end else begin
        run++;
      end
      pb = tr[k][1];
      pf = tr[k][0];
    end
    chk({tag, "_ngaps"}, ng, 3 * nseq - 1);
    chk({tag, "_gaplen_bad"}, bad, 0);
    chk({tag, "_busy_rises"}, brise, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_led"},   lv_a, 16'h1414);
    chk({tag, "_valid"}, bus_a.tx_valid, 0);
    chk({tag, "_frame"}, bus_a.tx_frame, 0);
    chk({tag, "_data"},  bus_a.tx_data, 8'h00);
    chk({tag, "_busy"},  busy_a, 0);
    chk({tag, "_tick"},  tick_a, 1);
  endtask

  task automatic clr();
    cap.delete();
    expq.delete();
    tr.delete();
  endtask

  initial begin
    int i;
    rst = 1; inc_a = 0; dec_a = 0; inc_bc = 0;
    load = 0; load_val = 0; rng = 0;
    mc[0] = 8'h14; mc[1] = 8'h14;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    chk("rst_tick_b", tick_b, 1);
    chk("rst_led_c", lv_c, 16'h1414);
    rst = 0;

    // single inc on ch0
    clr(); tr_en = 1;
    do_tick(2'b01, 2'b00, 2'b00, 0, 0);
    settle("t1");
    tr_en = 0;
    chk("t1_led", lv_a, 16'h1415);
    push_seq(8'h15, 8'h14, 2'b00);
    cmp_cap("t1");
    chk_gaps("t1", 1);

    // conflicting request on ch0, inc on ch1
    clr();
    do_tick(2'b11, 2'b01, 2'b00, 0, 0);
    settle("t3");
    chk("t3_led", lv_a, 16'h1515);
    push_seq(8'h15, 8'h15, 2'b00);
    cmp_cap("t3");

    // saturation and wrap
    do_tick(2'b00, 2'b00, 2'b00, 1, 16'hFEFE);
    settle("t2_load");
    clr();
    do_tick(2'b01, 2'b00, 2'b01, 0, 0);
    settle("t2a");
    chk("t2a_led_a", lv_a, 16'hFEFF);
    chk("t2a_led_b", lv_b, 16'hFEFF);
    chk("t2a_led_c", lv_c, 16'hFE02);
    chk("t2a_nbytes", cap.size(), 12);
    clr(); seen_b = 0;
    do_tick(2'b01, 2'b00, 2'b01, 0, 0);
    settle("t2b");
    chk("t2b_led_a", lv_a, 16'hFEFF);
    chk("t2b_led_b", lv_b, 16'hFEFF);
    chk("t2b_led_c", lv_c, 16'hFE06);
    chk("t2b_nbytes", cap.size(), 0);
    chk("t2b_busy_b", seen_b, 0);

    // change during LED_W byte 2 chains a second sequence
    do_tick(2'b00, 2'b00, 2'b00, 1, 16'h3040);
    settle("t4_load");
    clr(); rsp_dly = 9; tr_en = 1;
    do_tick(2'b01, 2'b00, 2'b00, 0, 0);
    push_seq(mc[0], mc[1], rng);
    i = 0;
    while (!(cap.size() == 6 && !bus_a.spi_done && tick_a) && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("t4_hit", cap.size(), 6);
    do_tick(2'b01, 2'b00, 2'b00, 0, 0);
    push_seq(mc[0], mc[1], rng);
    settle("t4");
    tr_en = 0; rsp_dly = 0;
    chk("t4_led", lv_a, 16'h3042);
    cmp_cap("t4");
    chk_gaps("t4", 2);

    // slow byte engine
    clr(); rsp_dly = 5; tr_en = 1;
    do_tick(2'b00, 2'b01, 2'b00, 0, 0);
    settle("t5");
    tr_en = 0; rsp_dly = 0;
    chk("t5_led", lv_a, 16'h3041);
    push_seq(8'h41, 8'h30, 2'b00);
    cmp_cap("t5");
    chk_gaps("t5", 1);

    // randomized adjust/load against the model
    for (int n = 0; n < 16; n++) begin
      logic [1:0]  ia, da;
      logic        ld;
      logic [15:0] lv;
      ia = 2'($urandom_range(0, 3));
      da = 2'($urandom_range(0, 3));
      ld = ($urandom_range(0, 4) == 0);
      lv = 16'($urandom);
      if ($urandom_range(0, 2) == 0) lv[7:0] = 8'hFF;
      if ($urandom_range(0, 2) == 0) lv[15:8] = 8'h00;
      rng = 2'($urandom_range(0, 3));
      clr();
      do_tick(ia, da, 2'b00, ld, lv);
      if (mchg) push_seq(mc[0], mc[1], rng);
      settle($sformatf("rnd%0d", n));
      chk($sformatf("rnd%0d_led", n), lv_a, model_led());
      cmp_cap($sformatf("rnd%0d", n));
    end

    // reset in the middle of LED_W
    rng = 0;
    do_tick(2'b00, 2'b00, 2'b00, 1, 16'h2020);
    settle("t6_load");
    clr();
    do_tick(2'b10, 2'b00, 2'b00, 0, 0);
    i = 0;
    while (!(cap.size() == 5 && !bus_a.spi_done) && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("t6_hit", cap.size(), 5);
    rst = 1;
    @(negedge clk);
    chk_reset("t6");
    rst = 0;
    mc[0] = 8'h14; mc[1] = 8'h14;
    repeat (2) @(negedge clk);
    clr();
    do_tick(2'b01, 2'b00, 2'b00, 0, 0);
    settle("t6_after");
    chk("t6_after_led", lv_a, 16'h1415);
    push_seq(8'h15, 8'h14, 2'b00);
    cmp_cap("t6_after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
